// File: rtl/sha_msg_sched.sv
// rtl/sha_msg_sched.sv - SHA-256/SHA-512 message schedule with a 16-word sliding window
module sha_msg_sched #(
  parameter int LAST_256 = 63,
  parameter int LAST_512 = 79
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          init_i,
  input  logic          enable_i,
  input  logic          mode_i,
  input  logic [1023:0] block_in_i,
  output logic [63:0]   w_out_o,
  output logic [6:0]    w_round_o,
  output logic          w_valid_o,
  output logic          sched_last_o
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [0:0]  state_q, state_d;
  logic        mode_q, mode_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [63:0] win_q [16];
  logic [63:0] win_d [16];
  logic [63:0] load_w [16];

  logic [6:0]  last_idx;
  logic [31:0] sig0_32, sig1_32, sum_32;
  logic [63:0] sig0_64, sig1_64, sum_64, new_word;
  logic [31:0] x1_32, x14_32;
  logic [63:0] x1_64, x14_64;

  assign last_idx = mode_q ? 7'(LAST_512) : 7'(LAST_256);

  // Sigma functions read the window slots that feed W_{t+16}.
  always_comb begin
    x1_32   = win_q[1][31:0];
    x14_32  = win_q[14][31:0];
    x1_64   = win_q[1];
    x14_64  = win_q[14];
    sig0_32 = {x1_32[6:0], x1_32[31:7]} ^ {x1_32[17:0], x1_32[31:18]} ^ (x1_32 >> 3);
    sig1_32 = {x14_32[16:0], x14_32[31:17]} ^ {x14_32[18:0], x14_32[31:19]} ^ (x14_32 >> 10);
    sig0_64 = {x1_64[0], x1_64[63:1]} ^ {x1_64[7:0], x1_64[63:8]} ^ (x1_64 >> 7);
    sig1_64 = {x14_64[18:0], x14_64[63:19]} ^ {x14_64[60:0], x14_64[63:61]} ^ (x14_64 >> 6);
    sum_32  = sig1_32 + win_q[9][31:0] + sig0_32 + win_q[0][31:0];
    sum_64  = sig1_64 + win_q[9] + sig0_64 + win_q[0];
    new_word = mode_q ? sum_64 : {32'h0, sum_32};
  end

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      load_w[i] = mode_i ? block_in_i[1023 - 64*i -: 64]
                         : {32'h0, block_in_i[511 - 32*i -: 32]};
    end
  end

  // init takes priority over enable; enable outside ACTIVE is ignored.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    if (init_i) begin
      state_d = ST_ACTIVE;
      mode_d  = mode_i;
      cnt_d   = 7'd0;
      win_d   = load_w;
    end else if (state_q == ST_ACTIVE && enable_i) begin
      if (cnt_q == last_idx) begin
        state_d = ST_IDLE;
      end else begin
        cnt_d = cnt_q + 7'd1;
        for (int i = 0; i < 15; i++) begin
          win_d[i] = win_q[i+1];
        end
        win_d[15] = new_word;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= 1'b0;
      cnt_q   <= 7'd0;
      for (int i = 0; i < 16; i++) begin
        win_q[i] <= 64'h0;
      end
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
    end
  end

  assign w_out_o      = win_q[0];
  assign w_round_o    = cnt_q;
  assign w_valid_o    = (state_q == ST_ACTIVE);
  assign sched_last_o = w_valid_o && (cnt_q == last_idx);

endmodule
